// File: rtl/axi_gran_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// axi_gran_write_buffer_pkg
// Shared types and helpers for the granular write buffer.
//   cnt_width(n) : bit width of a counter that must represent 0..n inclusive.
//   *_chan_t     : AXI channel payloads (AW/AR, W, B, R).
//   req_t/resp_t : bundled AXI request/response with valid/ready handshakes.
// -----------------------------------------------------------------------------
package axi_gran_write_buffer_pkg;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_chan_t;

    typedef aw_chan_t ar_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/axi_gran_write_buffer_cnt.sv
// -----------------------------------------------------------------------------
// axi_gran_write_buffer_cnt
// Up/down counter; a simultaneous increment and decrement leaves it unchanged.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count -> 0)
//   inc_i  : count up by one
//   dec_i  : count down by one
//   cnt_o  : current count
// -----------------------------------------------------------------------------
module axi_gran_write_buffer_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        (inc_i && !dec_i) |-> (cnt_q != '1));

    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        (dec_i && !inc_i) |-> (cnt_q != '0));

endmodule

// File: rtl/axi_gran_write_buffer.sv
// -----------------------------------------------------------------------------
// axi_gran_write_buffer
// Holds the W beats of each split write fragment and only releases the
// fragment's AW downstream once all its beats (through last) are buffered.
// AR, R and B are wired straight through.
// Ports:
//   clk_i          : clock
//   rst_i          : synchronous active-high reset; drops all buffered content
//   slv_req_i      : request from the burst splitter
//   slv_resp_o     : response to the burst splitter
//   mst_req_o      : request toward the interconnect
//   mst_resp_i     : response from the interconnect
//   full_o         : W FIFO full
//   num_complete_o : complete fragments held whose AW is not yet issued
// -----------------------------------------------------------------------------
module axi_gran_write_buffer
    import axi_gran_write_buffer_pkg::*;
#(
    parameter int unsigned WBufferDepth  = 16,
    parameter int unsigned MaxAwPending  = 8,
    parameter type         axi_req_t     = req_t,
    parameter type         axi_resp_t    = resp_t,
    parameter type         axi_aw_chan_t = aw_chan_t,
    parameter type         axi_w_chan_t  = w_chan_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  axi_req_t                              slv_req_i,
    output axi_resp_t                             slv_resp_o,
    output axi_req_t                              mst_req_o,
    input  axi_resp_t                             mst_resp_i,
    output logic                                  full_o,
    output logic [cnt_width(MaxAwPending)-1:0]    num_complete_o
);

    localparam int unsigned CntW   = cnt_width(MaxAwPending);
    localparam int unsigned AwOccW = cnt_width(MaxAwPending);
    localparam int unsigned WOccW  = cnt_width(WBufferDepth);
    localparam int unsigned AwPtrW = (MaxAwPending > 1) ? $clog2(MaxAwPending) : 1;
    localparam int unsigned WPtrW  = (WBufferDepth > 1) ? $clog2(WBufferDepth) : 1;

    localparam logic [AwPtrW-1:0] AwPtrLast = AwPtrW'(MaxAwPending - 1);
    localparam logic [WPtrW-1:0]  WPtrLast  = WPtrW'(WBufferDepth - 1);
    localparam logic [AwOccW-1:0] AwOccMax  = AwOccW'(MaxAwPending);
    localparam logic [WOccW-1:0]  WOccMax   = WOccW'(WBufferDepth);

    // FIFO storage and bookkeeping
    axi_aw_chan_t      aw_mem_q [MaxAwPending];
    axi_w_chan_t       w_mem_q  [WBufferDepth];
    logic [AwPtrW-1:0] aw_wr_q, aw_wr_d, aw_rd_q, aw_rd_d;
    logic [WPtrW-1:0]  w_wr_q, w_wr_d, w_rd_q, w_rd_d;
    logic [AwOccW-1:0] aw_occ_q, aw_occ_d;
    logic [WOccW-1:0]  w_occ_q, w_occ_d;

    logic aw_full, aw_empty, w_full, w_empty;
    logic slv_aw_ready, slv_w_ready;
    logic aw_push, w_push;
    logic mst_aw_valid, mst_w_valid;
    logic aw_hs, w_hs;
    logic [CntW-1:0] complete_cnt, w_credit;
    axi_w_chan_t w_head;

    assign aw_full  = (aw_occ_q == AwOccMax);
    assign aw_empty = (aw_occ_q == '0);
    assign w_full   = (w_occ_q == WOccMax);
    assign w_empty  = (w_occ_q == '0);
    assign w_head   = w_mem_q[w_rd_q];

    // Ready is withheld during reset so nothing is accepted into a FIFO that is
    // being cleared.
    assign slv_aw_ready = !rst_i && !aw_full;
    assign slv_w_ready  = !rst_i && !w_full;
    assign aw_push      = slv_req_i.aw_valid && slv_aw_ready;
    assign w_push       = slv_req_i.w_valid && slv_w_ready;

    // An AW leaves only when at least one whole fragment of W data is held.
    assign mst_aw_valid = !rst_i && !aw_empty && (complete_cnt != '0);
    assign aw_hs        = mst_aw_valid && mst_resp_i.aw_ready;

    // W may go out with its own AW in the same cycle; otherwise it needs a
    // credit from an AW already issued, so W never precedes its AW.
    assign mst_w_valid  = !rst_i && !w_empty && ((w_credit != '0) || aw_hs);
    assign w_hs         = mst_w_valid && mst_resp_i.w_ready;

    always_comb begin
        aw_wr_d  = aw_wr_q;
        aw_rd_d  = aw_rd_q;
        aw_occ_d = aw_occ_q;
        w_wr_d   = w_wr_q;
        w_rd_d   = w_rd_q;
        w_occ_d  = w_occ_q;

        if (aw_push) aw_wr_d = (aw_wr_q == AwPtrLast) ? '0 : aw_wr_q + 1'b1;
        if (aw_hs)   aw_rd_d = (aw_rd_q == AwPtrLast) ? '0 : aw_rd_q + 1'b1;
        if (aw_push && !aw_hs)      aw_occ_d = aw_occ_q + 1'b1;
        else if (!aw_push && aw_hs) aw_occ_d = aw_occ_q - 1'b1;

        if (w_push) w_wr_d = (w_wr_q == WPtrLast) ? '0 : w_wr_q + 1'b1;
        if (w_hs)   w_rd_d = (w_rd_q == WPtrLast) ? '0 : w_rd_q + 1'b1;
        if (w_push && !w_hs)      w_occ_d = w_occ_q + 1'b1;
        else if (!w_push && w_hs) w_occ_d = w_occ_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_wr_q  <= '0;
            aw_rd_q  <= '0;
            aw_occ_q <= '0;
            w_wr_q   <= '0;
            w_rd_q   <= '0;
            w_occ_q  <= '0;
        end else begin
            aw_wr_q  <= aw_wr_d;
            aw_rd_q  <= aw_rd_d;
            aw_occ_q <= aw_occ_d;
            w_wr_q   <= w_wr_d;
            w_rd_q   <= w_rd_d;
            w_occ_q  <= w_occ_d;
        end
    end

    // NOTE: the storage arrays carry no reset; the occupancy counters alone
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (aw_push) aw_mem_q[aw_wr_q] <= slv_req_i.aw;
        if (w_push)  w_mem_q[w_wr_q]   <= slv_req_i.w;
    end

    // Complete fragments held whose AW has not gone out yet.
    axi_gran_write_buffer_cnt #(.Width(CntW)) u_complete_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_push && slv_req_i.w.last),
        .dec_i (aw_hs),
        .cnt_o (complete_cnt)
    );

    // Issued AWs whose W data has not fully drained downstream.
    axi_gran_write_buffer_cnt #(.Width(CntW)) u_w_credit (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (aw_hs),
        .dec_i (w_hs && w_head.last),
        .cnt_o (w_credit)
    );

    // AR, R, B and their handshakes pass straight through; only AW and W
    // are sourced from the buffers.
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw       = aw_mem_q[aw_rd_q];
        mst_req_o.aw_valid = mst_aw_valid;
        mst_req_o.w        = w_head;
        mst_req_o.w_valid  = mst_w_valid;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = slv_aw_ready;
        slv_resp_o.w_ready  = slv_w_ready;
    end

    assign full_o         = w_full;
    assign num_complete_o = complete_cnt;

    // A fragment longer than the W buffer could never complete and would
    // deadlock the buffer.
    a_frag_fits : assert property (@(posedge clk_i) disable iff (rst_i)
        slv_req_i.aw_valid |-> (32'(slv_req_i.aw.len) < WBufferDepth));

endmodule
